// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA test-pattern generator.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_RAMP  = 2'd3
    } vga_mode_e;

    // 24-bit {r,g,b} bar colours; index 0 (leftmost bar) sits in the low slot.
    localparam logic [7:0][23:0] BAR_PALETTE = {
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Control inputs and video outputs of the pattern generator, bundled for port hookup.
interface vga_pattern_gen_if #(
    parameter int COLOR_W = 8
);
    logic                   enable;
    logic [1:0]             mode;
    logic [3*COLOR_W-1:0]   solid_rgb;
    logic [COLOR_W-1:0]     vga_r;
    logic [COLOR_W-1:0]     vga_g;
    logic [COLOR_W-1:0]     vga_b;
    logic                   vga_hs;
    logic                   vga_vs;
    logic                   video_on;
    logic [9:0]             x;
    logic [9:0]             y;
    logic                   frame_start;

    modport master (
        output enable, mode, solid_rgb,
        input  vga_r, vga_g, vga_b, vga_hs, vga_vs, video_on, x, y, frame_start
    );

    modport slave (
        input  enable, mode, solid_rgb,
        output vga_r, vga_g, vga_b, vga_hs, vga_vs, video_on, x, y, frame_start
    );
endinterface

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with combinational sync and active-region flags.
module vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_W      = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int V_W      = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic           clk_25,
    input  logic           rst,
    input  logic           enable,
    output logic [H_W-1:0] h_cnt,
    output logic [V_W-1:0] v_cnt,
    output logic           active,
    output logic           hs_on,
    output logic           vs_on
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT    = H_W'(H_ACTIVE);
    localparam logic [V_W-1:0] V_ACT    = V_W'(V_ACTIVE);
    localparam logic [H_W-1:0] HS_START = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [V_W-1:0] VS_START = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Counters simply stall while disabled so the raster resumes where it stopped.
    always_ff @(posedge clk_25) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (enable) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_on  = (h_cnt >= HS_START) && (h_cnt <= HS_END);
    assign vs_on  = (v_cnt >= VS_START) && (v_cnt <= VS_END);

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: solid, colour bars, checkerboard and ramp, all outputs
// registered one pixel clock behind the raster counters.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int COLOR_W  = 8,
    parameter int NUM_BARS = 4
) (
    input  logic              clk_25,
    input  logic              rst,
    vga_pattern_gen_if.slave  bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / NUM_BARS;
    localparam int BAR_CW  = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [H_W-1:0]    H_ACT    = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0]    H_ACT_LS = H_W'(H_ACTIVE - 1);
    localparam logic [BAR_CW-1:0] BAR_LAST = BAR_CW'(BAR_W - 1);

    logic [H_W-1:0]       h_cnt;
    logic [V_W-1:0]       v_cnt;
    logic                 active;
    logic                 hs_on;
    logic                 vs_on;
    logic                 at_origin;
    logic [9:0]           px;
    logic [9:0]           py;
    logic [BAR_CW-1:0]    bar_cnt;
    logic [2:0]           bar_idx;
    vga_mode_e            mode_q;
    vga_mode_e            mode_cur;
    logic [3*COLOR_W-1:0] rgb_q;
    logic [3*COLOR_W-1:0] rgb_cur;
    logic [23:0]          bar_rgb;
    logic [COLOR_W-1:0]   bar_r;
    logic [COLOR_W-1:0]   bar_g;
    logic [COLOR_W-1:0]   bar_b;
    logic [COLOR_W-1:0]   ramp;
    logic [COLOR_W-1:0]   pat_r;
    logic [COLOR_W-1:0]   pat_g;
    logic [COLOR_W-1:0]   pat_b;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .H_W      (H_W),
        .V_W      (V_W)
    ) u_timing (
        .clk_25 (clk_25),
        .rst    (rst),
        .enable (bus.enable),
        .h_cnt  (h_cnt),
        .v_cnt  (v_cnt),
        .active (active),
        .hs_on  (hs_on),
        .vs_on  (vs_on)
    );

    assign at_origin = (h_cnt == '0) && (v_cnt == '0);
    assign px        = 10'(h_cnt);
    assign py        = 10'(v_cnt);

    // Bar position tracks h_cnt so the index is ready for the pixel being computed.
    always_ff @(posedge clk_25) begin
        if (rst) begin
            bar_cnt <= '0;
            bar_idx <= '0;
        end else if (bus.enable && (h_cnt < H_ACT)) begin
            if (h_cnt == H_ACT_LS) begin
                bar_cnt <= '0;
                bar_idx <= '0;
            end else if (bar_cnt == BAR_LAST) begin
                bar_cnt <= '0;
                bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_cnt <= bar_cnt + 1'b1;
            end
        end
    end

    // The origin pixel already uses the newly sampled settings, so bypass the latch there.
    assign mode_cur = at_origin ? vga_mode_e'(bus.mode) : mode_q;
    assign rgb_cur  = at_origin ? bus.solid_rgb : rgb_q;

    always_ff @(posedge clk_25) begin
        if (rst) begin
            mode_q <= MODE_SOLID;
            rgb_q  <= '0;
        end else if (bus.enable && at_origin) begin
            mode_q <= vga_mode_e'(bus.mode);
            rgb_q  <= bus.solid_rgb;
        end
    end

    assign bar_rgb = BAR_PALETTE[bar_idx];

    generate
        if (COLOR_W <= 8) begin : g_bar_narrow
            assign bar_r = bar_rgb[23 -: COLOR_W];
            assign bar_g = bar_rgb[15 -: COLOR_W];
            assign bar_b = bar_rgb[7 -: COLOR_W];
        end else begin : g_bar_wide
            assign bar_r = {bar_rgb[23:16], {(COLOR_W - 8){bar_rgb[23]}}};
            assign bar_g = {bar_rgb[15:8],  {(COLOR_W - 8){bar_rgb[15]}}};
            assign bar_b = {bar_rgb[7:0],   {(COLOR_W - 8){bar_rgb[7]}}};
        end

        if (COLOR_W <= 10) begin : g_ramp_msb
            assign ramp = px[9 -: COLOR_W];
        end else begin : g_ramp_pad
            assign ramp = {px, {(COLOR_W - 10){1'b0}}};
        end
    endgenerate

    always_comb begin
        pat_r = '0;
        pat_g = '0;
        pat_b = '0;
        case (mode_cur)
            MODE_SOLID: {pat_r, pat_g, pat_b} = rgb_cur;
            MODE_BARS: begin
                pat_r = bar_r;
                pat_g = bar_g;
                pat_b = bar_b;
            end
            MODE_CHECK: begin
                if (px[5] ^ py[5]) begin
                    pat_r = '1;
                    pat_g = '1;
                    pat_b = '1;
                end
            end
            MODE_RAMP: begin
                pat_r = ramp;
                pat_g = ramp;
                pat_b = ramp;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_25) begin
        if (rst) begin
            bus.vga_r       <= '0;
            bus.vga_g       <= '0;
            bus.vga_b       <= '0;
            bus.vga_hs      <= ~HS_POL;
            bus.vga_vs      <= ~VS_POL;
            bus.video_on    <= 1'b0;
            bus.x           <= '0;
            bus.y           <= '0;
            bus.frame_start <= 1'b0;
        end else if (!bus.enable) begin
            bus.vga_r       <= '0;
            bus.vga_g       <= '0;
            bus.vga_b       <= '0;
            bus.vga_hs      <= ~HS_POL;
            bus.vga_vs      <= ~VS_POL;
            bus.video_on    <= 1'b0;
            bus.frame_start <= 1'b0;
        end else begin
            bus.vga_r       <= active ? pat_r : '0;
            bus.vga_g       <= active ? pat_g : '0;
            bus.vga_b       <= active ? pat_b : '0;
            bus.vga_hs      <= hs_on ? HS_POL : ~HS_POL;
            bus.vga_vs      <= vs_on ? VS_POL : ~VS_POL;
            bus.video_on    <= active;
            bus.frame_start <= at_origin;
            if (active) begin
                bus.x <= px;
                bus.y <= py;
            end
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen on a shrunken raster: every cycle is compared
// against a linear-position reference model, plus table vectors and timing sequences.
module tb_vga_pattern_gen;

    localparam int HA = 64, HFP = 4, HSW = 8, HBP = 4;
    localparam int VA = 40, VFP = 2, VSW = 2, VBP = 3;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;
    localparam int NB = 4;
    localparam bit HS_POL = 1'b0;
    localparam bit VS_POL = 1'b1;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       hs;
        logic       vs;
        logic       von;
        logic [9:0] x;
        logic [9:0] y;
        logic       fs;
    } out_t;

    typedef struct {
        logic [1:0]  mode;
        logic [23:0] solid;
        bit          new_frame;
        int          px;
        int          py;
        logic [23:0] exp_rgb;
    } vec_t;

    logic clk_25 = 1'b0;
    logic rst;

    vga_pattern_gen_if #(.COLOR_W(8)) bus ();

    vga_pattern_gen #(
        .H_ACTIVE (HA),  .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
        .V_ACTIVE (VA),  .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
        .HS_POL   (HS_POL), .VS_POL (VS_POL), .COLOR_W (8), .NUM_BARS (NB)
    ) dut (
        .clk_25 (clk_25),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_25 = ~clk_25;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: raster position as one linear index into the frame.
    int          m_pos = 0;
    logic [1:0]  m_mode = 2'd0;
    logic [23:0] m_rgb = 24'h0;
    int          m_x = 0;
    int          m_y = 0;
    int          last_h, last_v;
    bit          last_active, last_origin;

    int hs_fall[$], vs_fall[$], fs_at[$], hs_runs[$], vs_runs[$];
    vec_t vecs[15];

    function automatic logic [23:0] bar_colour(int idx);
        case (idx)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [23:0] ref_pixel(logic [1:0] md, logic [23:0] solid, int h, int v);
        logic [7:0] lvl;
        case (md)
            2'd0: return solid;
            2'd1: return bar_colour(h / (HA / NB));
            2'd2: return (((h / 32) + (v / 32)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
            default: begin
                lvl = 8'((h / 4) % 256);
                return {lvl, lvl, lvl};
            end
        endcase
    endfunction

    function automatic out_t dut_out();
        return {bus.vga_r, bus.vga_g, bus.vga_b, bus.vga_hs, bus.vga_vs,
                bus.video_on, bus.x, bus.y, bus.frame_start};
    endfunction

    task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, got, want);
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic en, input logic [1:0] md,
                                  input logic [23:0] rgb);
        rst           = r;
        bus.enable    = en;
        bus.mode      = md;
        bus.solid_rgb = rgb;
    endtask

    // Predict the outputs the next edge must produce, advance the model, then compare.
    task automatic step();
        out_t e;
        int h, v;
        logic [23:0] pix;
        h = m_pos % HT;
        v = m_pos / HT;
        last_active = 1'b0;
        last_origin = 1'b0;
        e = '0;
        e.hs = ~HS_POL;
        e.vs = ~VS_POL;
        if (rst) begin
            m_pos = 0; m_mode = 2'd0; m_rgb = 24'h0; m_x = 0; m_y = 0;
        end else if (bus.enable) begin
            if (m_pos == 0) begin
                m_mode = bus.mode;
                m_rgb = bus.solid_rgb;
                last_origin = 1'b1;
            end
            last_h = h;
            last_v = v;
            last_active = (h < HA) && (v < VA);
            if (last_active) begin
                m_x = h;
                m_y = v;
                pix = ref_pixel(m_mode, m_rgb, h, v);
                {e.r, e.g, e.b} = pix;
            end
            e.hs = (h >= HA + HFP && h < HA + HFP + HSW) ? HS_POL : ~HS_POL;
            e.vs = (v >= VA + VFP && v < VA + VFP + VSW) ? VS_POL : ~VS_POL;
            e.von = last_active;
            e.fs = (m_pos == 0);
            m_pos = (m_pos + 1) % FRAME;
        end
        e.x = 10'(m_x);
        e.y = 10'(m_y);
        @(posedge clk_25);
        #1;
        check_output("cycle", 64'(dut_out()), 64'(e));
    endtask

    task automatic goto_pixel(input int px, input int py, input bit nf, output bit ok);
        bit armed;
        armed = !nf;
        ok = 1'b0;
        for (int c = 0; c < 3 * FRAME; c++) begin
            step();
            if (last_origin) armed = 1'b1;
            if (armed && last_active && last_h == px && last_v == py) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit ok, found, cur, prev_h, prev_v;
        int hs_run, vs_run, en_steps;
        out_t rst_exp;

        vecs[0]  = '{2'd1, 24'h0,      1'b1,  0,  3, 24'hFFFFFF};
        vecs[1]  = '{2'd1, 24'h0,      1'b0, 15,  3, 24'hFFFFFF};
        vecs[2]  = '{2'd1, 24'h0,      1'b0, 16,  3, 24'hFFFF00};
        vecs[3]  = '{2'd1, 24'h0,      1'b0, 32,  3, 24'h00FFFF};
        vecs[4]  = '{2'd1, 24'h0,      1'b0, 48,  3, 24'h00FF00};
        vecs[5]  = '{2'd1, 24'h0,      1'b0, 63,  3, 24'h00FF00};
        vecs[6]  = '{2'd0, 24'h123456, 1'b1,  5,  5, 24'h123456};
        vecs[7]  = '{2'd2, 24'h123456, 1'b0, 32, 32, 24'h123456};
        vecs[8]  = '{2'd2, 24'h123456, 1'b1, 32,  0, 24'hFFFFFF};
        vecs[9]  = '{2'd2, 24'h123456, 1'b0,  0, 32, 24'hFFFFFF};
        vecs[10] = '{2'd2, 24'h123456, 1'b0, 32, 32, 24'h000000};
        vecs[11] = '{2'd3, 24'h0,      1'b1,  0,  1, 24'h000000};
        vecs[12] = '{2'd3, 24'h0,      1'b0, 16,  1, 24'h040404};
        vecs[13] = '{2'd3, 24'h0,      1'b0, 63,  1, 24'h0F0F0F};
        vecs[14] = '{2'd3, 24'h0,      1'b0, 40, 39, 24'h0A0A0A};

        rst_exp = '0;
        rst_exp.hs = ~HS_POL;
        rst_exp.vs = ~VS_POL;

        apply_stimulus(1'b1, 1'b0, 2'd0, 24'h0);
        repeat (3) step();
        check_output("reset_state", 64'(dut_out()), 64'(rst_exp));

        // Raster period and sync widths over two full frames.
        apply_stimulus(1'b0, 1'b1, 2'd0, 24'h0);
        prev_h = 1'b0; prev_v = 1'b0; hs_run = 0; vs_run = 0;
        for (int c = 0; c < 2 * FRAME + HT; c++) begin
            step();
            cur = (bus.vga_hs == HS_POL);
            if (cur && !prev_h) hs_fall.push_back(c);
            if (cur) hs_run++;
            else if (prev_h) begin hs_runs.push_back(hs_run); hs_run = 0; end
            prev_h = cur;
            cur = (bus.vga_vs == VS_POL);
            if (cur && !prev_v) vs_fall.push_back(c);
            if (cur) vs_run++;
            else if (prev_v) begin vs_runs.push_back(vs_run); vs_run = 0; end
            prev_v = cur;
            if (bus.frame_start) fs_at.push_back(c);
        end
        check_output("fs_count", fs_at.size(), 3);
        if (hs_fall.size() >= 2 && hs_runs.size() >= 1) begin
            check_output("hs_period", hs_fall[1] - hs_fall[0], HT);
            check_output("hs_width", hs_runs[0], HSW);
        end else check_output("hs_edges", hs_fall.size(), 2);
        if (vs_fall.size() >= 2 && vs_runs.size() >= 1) begin
            check_output("vs_period", vs_fall[1] - vs_fall[0], FRAME);
            check_output("vs_width", vs_runs[0], VSW * HT);
        end else check_output("vs_edges", vs_fall.size(), 2);
        if (fs_at.size() >= 2) check_output("fs_period", fs_at[1] - fs_at[0], FRAME);

        // Table vectors: pattern colour at chosen pixels, including a mid-frame mode switch.
        for (int i = 0; i < 15; i++) begin
            apply_stimulus(1'b0, 1'b1, vecs[i].mode, vecs[i].solid);
            goto_pixel(vecs[i].px, vecs[i].py, vecs[i].new_frame, ok);
            check_output($sformatf("reach%0d", i), 64'(ok), 64'(1));
            check_output($sformatf("vec%0d", i), {bus.vga_r, bus.vga_g, bus.vga_b},
                         vecs[i].exp_rgb);
        end

        // Freeze mid-line for 100 cycles; the line must still be HT enabled cycles long.
        apply_stimulus(1'b0, 1'b1, 2'd1, 24'h0);
        prev_h = (bus.vga_hs == HS_POL);
        found = 1'b0;
        for (int c = 0; c < 2 * HT + 2; c++) begin
            step();
            cur = (bus.vga_hs == HS_POL);
            if (cur && !prev_h) begin found = 1'b1; break; end
            prev_h = cur;
        end
        check_output("hs_edge_found", 64'(found), 64'(1));
        en_steps = 0;
        repeat (20) begin step(); en_steps++; end
        apply_stimulus(1'b0, 1'b0, 2'd1, 24'h0);
        repeat (100) step();
        check_output("freeze_rgb", {bus.vga_r, bus.vga_g, bus.vga_b}, 0);
        check_output("freeze_ctrl", {bus.vga_hs, bus.vga_vs, bus.video_on, bus.frame_start},
                     {~HS_POL, ~VS_POL, 2'b00});
        apply_stimulus(1'b0, 1'b1, 2'd1, 24'h0);
        prev_h = 1'b0;
        for (int c = 0; c < 2 * HT; c++) begin
            step();
            en_steps++;
            cur = (bus.vga_hs == HS_POL);
            if (cur && !prev_h) break;
            prev_h = cur;
        end
        check_output("line_len", en_steps, HT);

        // Reset mid-frame, then the origin pixel and frame_start right after release.
        found = 1'b0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            step();
            if (last_active && last_v == 20 && last_h == 10) begin found = 1'b1; break; end
        end
        check_output("reach_y20", 64'(found), 64'(1));
        apply_stimulus(1'b1, 1'b1, 2'd2, 24'h0);
        step();
        check_output("rst_outputs", 64'(dut_out()), 64'(rst_exp));
        apply_stimulus(1'b0, 1'b1, 2'd2, 24'h0);
        step();
        check_output("fs_after_rst", 64'(bus.frame_start), 64'(1));
        check_output("origin_after_rst", {bus.x, bus.y, bus.video_on}, {20'd0, 1'b1});

        // Randomised enable gaps, mode/colour changes and occasional resets.
        for (int c = 0; c < 12000; c++) begin
            logic en, r;
            logic [1:0] md;
            logic [23:0] sc;
            en = bus.enable; md = bus.mode; sc = bus.solid_rgb; r = 1'b0;
            if (bus.enable) begin
                if ($urandom_range(0, 99) < 2) en = 1'b0;
            end else if ($urandom_range(0, 99) < 25) en = 1'b1;
            if ($urandom_range(0, 299) == 0) md = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) sc = 24'($urandom);
            if ($urandom_range(0, 3999) == 0) r = 1'b1;
            apply_stimulus(r, en, md, sc);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 SHALL have parameters H_ACTIVE=640, H_FP=16, H_SYNC=96, H_BP=48 (horizontal timing, pixels).
REQ-002 SHALL have parameters V_ACTIVE=480, V_FP=10, V_SYNC=2, V_BP=33 (vertical timing, lines).
REQ-003 SHALL have parameters HS_POL=0 and VS_POL=0 (sync level while asserted), COLOR_W=8 (bits per channel), NUM_BARS=4 (vertical bar count, 1..8, H_ACTIVE divisible by NUM_BARS).
REQ-004 clk_25  in  1  pixel clock; one clock domain.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 enable  in  1  1 = run timing; 0 = freeze counters and blank outputs.
REQ-007 mode  in  2  pattern select: 0 solid, 1 vertical bars, 2 checkerboard, 3 horizontal ramp.
REQ-008 solid_rgb  in  3*COLOR_W  colour for mode 0, {r,g,b}.
REQ-009 vga_r, vga_g, vga_b  out  COLOR_W each  pixel colour.
REQ-010 vga_hs, vga_vs  out  1 each  sync outputs, polarity per HS_POL/VS_POL.
REQ-011 video_on  out  1  high during active region.
REQ-012 x, y  out  10 each  active-region pixel coordinates, aligned with RGB.
REQ-013 frame_start  out  1  one-cycle pulse coincident with x=0, y=0 active pixel.

Function
REQ-014 Internal h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of H params), wrapping to 0; v_cnt SHALL increment when h_cnt wraps and itself wrap at V_TOTAL-1.
REQ-015 Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE; sync asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], likewise vertical.
REQ-016 All outputs SHALL be registered with exactly 1 clk_25 latency from counter state; hs, vs, video_on, x, y, RGB mutually aligned.
REQ-017 Outside active region RGB SHALL be 0; x, y SHALL hold their last active value.
REQ-018 mode and solid_rgb SHALL be sampled only when h_cnt=0 and v_cnt=0 (frame boundary); mid-frame changes take effect next frame.
REQ-019 Mode 1: bar index SHALL increment every H_ACTIVE/NUM_BARS pixels via a sub-counter (no divider); colour = palette[index].
REQ-020 Mode 2: pixel white (all ones) when x[5] XOR y[5] = 1, else black.
REQ-021 Mode 3: each channel = x[9 -: COLOR_W] when COLOR_W<=10, zero-extended on the LSB side otherwise.
REQ-022 enable=0: counters hold value; hs, vs at inactive level; video_on, RGB, frame_start = 0; on re-enable counting resumes from held value.
REQ-023 Counter widths SHALL be $clog2 of totals; no overflow at any legal parameter set.

Reset
REQ-024 On rst=1 at a clk_25 edge: h_cnt=0, v_cnt=0, bar sub-counter=0, latched mode=0, latched colour=0.
REQ-025 Outputs during and one cycle after reset: RGB=0, video_on=0, frame_start=0, x=y=0, syncs inactive.
REQ-026 Reset mid-frame SHALL abort the frame; first frame_start after release occurs 1 cycle after rst deasserts (counter at 0,0).

Structure
REQ-027 Package vga_pkg SHALL hold the mode enum (MODE_SOLID, MODE_BARS, MODE_CHECK, MODE_RAMP) and the 8-entry 24-bit bar palette (white, yellow, cyan, green, magenta, red, blue, black).
REQ-028 Timing counters SHALL be a sub-module vga_timing (h/v counters, sync, active flag); pattern logic stays in vga_pattern_gen.

Verification
REQ-029 Reset then run 2 frames default params -> hs period 800 cycles, low for 96; vs period 420000 cycles, low for 2 lines; frame_start once per 420000.
REQ-030 mode=1, NUM_BARS=4 -> line pixels 0-159 white (FFFFFF), 160-319 yellow (FFFF00), 320-479 cyan (00FFFF), 480-639 green (00FF00); blanking 0.
REQ-031 mode=0 solid_rgb=123456, switch to mode=2 mid-frame -> rest of frame stays 123456; next frame pixel (32,0)=FFFFFF, (32,32)=000000.
REQ-032 mode=3 -> x=0 gives 00, x=639 gives 9F on all channels.
REQ-033 enable low for 100 cycles mid-line -> syncs inactive, RGB 0; after re-enable h_cnt continues from frozen value, total line still 800 enabled cycles.
REQ-034 rst pulse at y=200 -> next cycle outputs reset values; frame_start asserted 1 cycle after rst release.
